// File: rtl/irq_prio_sched.sv
// Interrupt arbitration core: edge-latches NUM_IRQ lines into a pending set,
// picks the highest-priority enabled line and holds it until acknowledged.
module irq_prio_sched #(
  parameter int NUM_IRQ = 8,
  parameter int PRIO_W  = 2,
  parameter int ID_W    = 3
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic [NUM_IRQ-1:0]        irq_in,
  input  logic [NUM_IRQ-1:0]        mask,
  input  logic [NUM_IRQ*PRIO_W-1:0] prio,
  input  logic                      global_en,
  input  logic                      ack,
  input  logic                      ovr_clr,
  output logic                      irq_out,
  output logic [ID_W-1:0]           irq_id,
  output logic [NUM_IRQ-1:0]        pending,
  output logic [NUM_IRQ-1:0]        overrun,
  output logic                      busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARB    = 2'd1,
    ASSERT = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_IRQ-1:0]  irq_q;
  logic [NUM_IRQ-1:0]  pending_q, pending_d;
  logic [NUM_IRQ-1:0]  overrun_q, overrun_d;
  logic [ID_W-1:0]     irq_id_q, irq_id_d;

  logic [NUM_IRQ-1:0]  rise;
  logic [NUM_IRQ-1:0]  clr;
  logic [NUM_IRQ-1:0]  elig;
  logic [ID_W-1:0]     win_id;
  logic [PRIO_W-1:0]   win_prio;
  logic                win_found;
  logic                ack_ok;

  assign rise   = irq_in & ~irq_q;
  assign elig   = pending_q & mask;
  assign ack_ok = ack && (state_q == ASSERT);
  assign clr    = ack_ok ? (NUM_IRQ'(1) << irq_id_q) : '0;

  // A rise on the line being retired re-pends it without counting as overrun.
  assign pending_d = (pending_q & ~clr) | rise;
  assign overrun_d = (ovr_clr ? '0 : overrun_q) | (rise & pending_q & ~clr);

  // Ascending scan with strict compare keeps the lowest index on ties.
  always_comb begin
    win_id    = '0;
    win_prio  = '0;
    win_found = 1'b0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (elig[i] && (!win_found || (prio[i*PRIO_W +: PRIO_W] > win_prio))) begin
        win_found = 1'b1;
        win_prio  = prio[i*PRIO_W +: PRIO_W];
        win_id    = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      IDLE: begin
        if (global_en && (elig != '0)) state_d = ARB;
      end
      ARB: begin
        if (elig != '0) begin
          irq_id_d = win_id;
          state_d  = ASSERT;
        end else begin
          state_d = IDLE;
        end
      end
      ASSERT: begin
        if (ack)             state_d = DONE;
        else if (!global_en) state_d = IDLE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q   <= IDLE;
      irq_q     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      irq_q     <= irq_in;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign irq_out = (state_q == ASSERT);
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign overrun = overrun_q;
  assign busy    = (state_q != IDLE);

endmodule
